// File: rtl/icon_tx_arbiter.sv
// icon_tx_arbiter: round-robin arbiter funnelling execution-unit write results onto one interconnect tx channel
package pkg_dtypes;
  typedef struct packed {
    logic [31:0] opd_data;
    logic [15:0] opd_addr;
    logic        opd_opx;
    logic        opd_valid;
  } type_alu_channel_tx;
  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
    logic        valid;
  } type_icon_tx_channel;
  typedef struct packed {
    logic success;
  } type_icon_rx_channel;
endpackage

`ifndef NUM_EXEC_UNITS
`define NUM_EXEC_UNITS 4
`endif

module icon_tx_arbiter #(
  parameter int NUM_REQ  = `NUM_EXEC_UNITS,
  parameter int MAX_WAIT = 15,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int WW = $clog2(MAX_WAIT + 1)
) (
  input  logic                                         clk,
  input  logic                                         reset_n,
  input  pkg_dtypes::type_alu_channel_tx [NUM_REQ-1:0] eu_tx,
  output logic [NUM_REQ-1:0]                           eu_tx_ready,
  output pkg_dtypes::type_icon_tx_channel              icon_tx,
  output logic                                         icon_opx,
  input  pkg_dtypes::type_icon_rx_channel              icon_rx,
  output logic [IW-1:0]                                grant_idx,
  output logic                                         busy
);
  typedef enum logic {IDLE, SEND} state_e;
  typedef struct packed {
    logic [31:0] data;
    logic [15:0] addr;
    logic        opx;
  } entry_t;

  state_e                    state_q, state_d;
  entry_t [NUM_REQ-1:0]      hold_q, hold_d;
  logic   [NUM_REQ-1:0]      hold_valid_q, hold_valid_d;
  logic   [IW-1:0]           rr_ptr_q, rr_ptr_d;
  logic   [IW-1:0]           grant_q, grant_d;
  logic   [WW-1:0]           wait_q, wait_d;
  logic   [IW-1:0]           sel;
  logic                      found;
  logic   [IW-1:0]           grant_nxt;

  assign eu_tx_ready = ~hold_valid_q;
  assign busy        = (state_q == SEND);
  assign grant_idx   = grant_q;
  assign grant_nxt   = (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
  assign icon_tx     = busy ? {hold_q[grant_q].addr, hold_q[grant_q].data, 1'b1} : '0;
  assign icon_opx    = busy & hold_q[grant_q].opx;

  // first held slot at or after rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    logic [IW:0] idx;
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (IW+1)'(rr_ptr_q) + (IW+1)'(k);
      idx = (idx >= (IW+1)'(NUM_REQ)) ? idx - (IW+1)'(NUM_REQ) : idx;
      if (!found && hold_valid_q[idx[IW-1:0]]) begin
        found = 1'b1;
        sel   = idx[IW-1:0];
      end
    end
  end

  // slot capture plus IDLE/SEND next-state; capture and release of different slots coexist
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    wait_d       = wait_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (eu_tx[i].opd_valid && !hold_valid_q[i]) begin
        hold_valid_d[i] = 1'b1;
        hold_d[i]       = '{data: eu_tx[i].opd_data, addr: eu_tx[i].opd_addr, opx: eu_tx[i].opd_opx};
      end
    end
    if (state_q == IDLE) begin
      if (found) begin
        state_d = SEND;
        grant_d = sel;
        wait_d  = '0;
      end
    end else if (icon_rx.success) begin
      hold_valid_d[grant_q] = 1'b0;
      rr_ptr_d              = grant_nxt;
      state_d               = IDLE;
    end else if (wait_q == WW'(MAX_WAIT - 1)) begin
      rr_ptr_d = grant_nxt;
      state_d  = IDLE;
    end else begin
      wait_d = wait_q + 1'b1;
    end
  end

  // state registers; reset drops every held entry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      hold_valid_q <= '0;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      wait_q       <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      wait_q       <= wait_d;
    end
  end
endmodule

// File: tb/tb_icon_tx_arbiter.sv
// tb_icon_tx_arbiter: directed self-checking bench for icon_tx_arbiter
module tb_icon_tx_arbiter;
  import pkg_dtypes::*;

  logic                      clk = 1'b0;
  logic                      reset_n = 1'b0;
  type_alu_channel_tx [3:0]  eu_tx;
  logic [3:0]                eu_tx_ready;
  type_icon_tx_channel       icon_tx;
  logic                      icon_opx;
  type_icon_rx_channel       icon_rx;
  logic [1:0]                grant_idx;
  logic                      busy;
  int                        n_chk = 0;
  int                        n_pass = 0;
  int                        cnt;

  icon_tx_arbiter #(.NUM_REQ(4), .MAX_WAIT(15)) dut (
    .clk(clk), .reset_n(reset_n), .eu_tx(eu_tx), .eu_tx_ready(eu_tx_ready),
    .icon_tx(icon_tx), .icon_opx(icon_opx), .icon_rx(icon_rx),
    .grant_idx(grant_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset;
    eu_tx = '0;
    icon_rx = '0;
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  task automatic put(input int i, input logic [15:0] a, input logic [31:0] d, input logic o);
    eu_tx[i] = '{opd_data: d, opd_addr: a, opd_opx: o, opd_valid: 1'b1};
  endtask

  initial begin
    eu_tx = '0;
    icon_rx = '0;
    #3;
    check("rst_ready", 64'(eu_tx_ready), 64'hF);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_icon_tx", 64'(icon_tx), 64'h0);
    check("rst_opx", 64'(icon_opx), 64'h0);
    check("rst_grant", 64'(grant_idx), 64'h0);
    step;
    reset_n = 1'b1;
    step;
    // single request, success ignored while IDLE
    icon_rx.success = 1'b1;
    put(2, 16'h00A0, 32'h1234, 1'b1);
    step;
    eu_tx = '0;
    check("single_ready_held", 64'(eu_tx_ready), 64'hB);
    check("single_idle", 64'(busy), 64'h0);
    step;
    check("single_busy", 64'(busy), 64'h1);
    check("single_grant", 64'(grant_idx), 64'h2);
    check("single_tx", 64'(icon_tx), 64'({16'h00A0, 32'h1234, 1'b1}));
    check("single_opx", 64'(icon_opx), 64'h1);
    step;
    check("single_done_busy", 64'(busy), 64'h0);
    check("single_done_tx", 64'(icon_tx), 64'h0);
    check("single_done_ready", 64'(eu_tx_ready), 64'hF);
    check("single_rr_ptr", 64'(dut.rr_ptr_q), 64'h3);
    // fairness with all requesters valid and success always high
    pulse_reset;
    icon_rx.success = 1'b1;
    for (int i = 0; i < 4; i++) put(i, 16'(i), 32'(i * 16), 1'b0);
    step;
    for (int g = 0; g < 8; g++) begin
      step;
      check("rr_busy", 64'(busy), 64'h1);
      check("rr_grant", 64'(grant_idx), 64'(g % 4));
      step;
      check("rr_gap", 64'(busy), 64'h0);
    end
    // timeout with a sole holder
    pulse_reset;
    put(1, 16'h0055, 32'hBEEF, 1'b0);
    step;
    eu_tx = '0;
    step;
    cnt = 0;
    while (busy && cnt < 40) begin
      cnt++;
      step;
    end
    check("tmo_len", 64'(cnt), 64'd15);
    check("tmo_kept", 64'(eu_tx_ready), 64'hD);
    step;
    check("tmo_regrant", 64'(grant_idx), 64'h1);
    check("tmo_entry", 64'(icon_tx), 64'({16'h0055, 32'hBEEF, 1'b1}));
    icon_rx.success = 1'b1;
    step;
    icon_rx.success = 1'b0;
    check("tmo_cleared", 64'(eu_tx_ready), 64'hF);
    // timeout with a contender waiting
    pulse_reset;
    put(1, 16'h0011, 32'h1111, 1'b0);
    step;
    eu_tx = '0;
    step;
    put(2, 16'h0022, 32'h2222, 1'b1);
    step;
    eu_tx = '0;
    cnt = 1;
    while (busy && cnt < 40) begin
      cnt++;
      step;
    end
    check("cont_tmo_len", 64'(cnt), 64'd15);
    check("cont_ready", 64'(eu_tx_ready), 64'h9);
    step;
    check("cont_grant2", 64'(grant_idx), 64'h2);
    check("cont_opx", 64'(icon_opx), 64'h1);
    icon_rx.success = 1'b1;
    step;
    icon_rx.success = 1'b0;
    check("cont_ready2", 64'(eu_tx_ready), 64'hD);
    step;
    check("cont_grant1", 64'(grant_idx), 64'h1);
    check("cont_busy1", 64'(busy), 64'h1);
    icon_rx.success = 1'b1;
    step;
    icon_rx.success = 1'b0;
    check("cont_clear", 64'(eu_tx_ready), 64'hF);
    // release on slot 0 and capture at slot 3 on the same edge
    pulse_reset;
    put(0, 16'h0100, 32'hAAAA, 1'b0);
    step;
    eu_tx = '0;
    step;
    check("sim_grant0", 64'(grant_idx), 64'h0);
    icon_rx.success = 1'b1;
    put(3, 16'h0300, 32'h3333, 1'b1);
    step;
    eu_tx = '0;
    icon_rx.success = 1'b0;
    check("sim_ready", 64'(eu_tx_ready), 64'h7);
    check("sim_idle", 64'(busy), 64'h0);
    step;
    check("sim_grant3", 64'(grant_idx), 64'h3);
    check("sim_tx3", 64'(icon_tx), 64'({16'h0300, 32'h3333, 1'b1}));
    icon_rx.success = 1'b1;
    step;
    icon_rx.success = 1'b0;
    // asynchronous reset in the middle of SEND
    pulse_reset;
    put(0, 16'h0001, 32'h0101, 1'b1);
    put(1, 16'h0002, 32'h0202, 1'b1);
    step;
    eu_tx = '0;
    step;
    check("arst_pre_busy", 64'(busy), 64'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_tx", 64'(icon_tx), 64'h0);
    check("arst_ready", 64'(eu_tx_ready), 64'hF);
    check("arst_busy", 64'(busy), 64'h0);
    #1;
    reset_n = 1'b1;
    icon_rx.success = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step;
      check("arst_no_send", 64'(busy), 64'h0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
